// File: rtl/mips_boot_sequencer_pkg.sv
// Shared types and constants for the MIPS boot sequencer.
package mips_boot_sequencer_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        RESET_CPU = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } seq_state_t;

    // Instruction word that terminates a run
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_run_monitor.sv
// Supervises the RUN phase: counts run cycles, detects the halt word or the
// cycle limit, and captures the PC at halt.
module mips_run_monitor
    import mips_boot_sequencer_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          MAX_CYCLES = 100000,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    output logic             halt_hit,
    output logic             limit_hit,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      halt_pc,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

    // Halt takes precedence over the cycle limit when both occur together
    always_comb begin
        halt_hit  = run && (instr_in == HALT_INSTR);
        limit_hit = run && !halt_hit && (cycle_count == LIMIT);
    end

    // Run-cycle counter (saturating), halt PC capture and sticky timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            halt_pc     <= '0;
            timeout     <= 1'b0;
        end else if (clear) begin
            cycle_count <= '0;
            halt_pc     <= '0;
            timeout     <= 1'b0;
        end else begin
            if (run && !halt_hit && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (halt_hit) begin
                halt_pc <= pc_in;
            end
            if (limit_hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_boot_sequencer.sv
// Load/run controller for the MIPS core: streams a program into instruction
// memory through the core's init port, pulses the core reset, then supervises
// execution until a halt word or the run-cycle limit.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start, core held in reset
// LOAD      | accepting source words, one memory write per accept
// RESET_CPU | core held in reset with init_mode for RST_CYCLES cycles
// RUN       | core running, monitor counts cycles and watches for halt
// DONE      | run finished, status held, core back in reset
module mips_boot_sequencer
    import mips_boot_sequencer_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter int          RST_CYCLES = 2,
    parameter int          MAX_CYCLES = 100000,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   load_count,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              cpu_reset,
    output logic              init_mode,
    output logic              write_enable,
    output logic [ADDR_W-1:0] init_address,
    output logic [31:0]       init_instruction,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       instr_in,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [31:0]       halt_pc
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [ADDR_W:0] MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [RW-1:0]   RST_LOAD  = RW'(RST_CYCLES - 1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [ADDR_W:0]   n_total;
    logic [ADDR_W:0]   load_clamped;
    logic [ADDR_W-1:0] idx;
    logic [RW-1:0]     rst_cnt;
    logic              accept;
    logic              last_word;
    logic              start_clear;
    logic              mon_clear;
    logic              halt_hit;
    logic              limit_hit;

    // Handshake, clamp and terminal-word decode
    always_comb begin
        s_ready      = (state == LOAD);
        accept       = s_ready && s_valid;
        load_clamped = (load_count > MEM_WORDS) ? MEM_WORDS : load_count;
        last_word    = ({1'b0, idx} == (n_total - 1'b1));
        start_clear  = start && !abort && ((state == IDLE) || (state == DONE));
        mon_clear    = abort || start_clear;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = (load_clamped == '0) ? RESET_CPU : LOAD;
                end
            end
            LOAD: begin
                if (accept && last_word) begin
                    next_state = RESET_CPU;
                end
            end
            RESET_CPU: begin
                if (rst_cnt == '0) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (halt_hit || limit_hit) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs follow the next state so they line up with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset <= 1'b1;
            init_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cpu_reset <= (next_state != RUN);
            init_mode <= (next_state == LOAD) || (next_state == RESET_CPU);
            busy      <= (next_state == LOAD) || (next_state == RESET_CPU) ||
                         (next_state == RUN);
            done      <= (next_state == DONE);
        end
    end

    // Load datapath: one write pulse per accepted word, index saturates at the top
    always_ff @(posedge clk) begin
        if (reset) begin
            n_total          <= '0;
            idx              <= '0;
            write_enable     <= 1'b0;
            init_address     <= '0;
            init_instruction <= '0;
        end else begin
            write_enable <= accept && !abort;
            if (accept && !abort) begin
                init_address     <= idx;
                init_instruction <= s_data;
                if (idx != '1) begin
                    idx <= idx + 1'b1;
                end
            end
            if (start_clear) begin
                n_total <= load_clamped;
                idx     <= '0;
            end
        end
    end

    // Core-reset hold timer, loaded on entry to RESET_CPU and counted down
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt <= '0;
        end else if ((next_state == RESET_CPU) && (state != RESET_CPU)) begin
            rst_cnt <= RST_LOAD;
        end else if ((state == RESET_CPU) && (rst_cnt != '0)) begin
            rst_cnt <= rst_cnt - 1'b1;
        end
    end

    mips_run_monitor #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES),
        .HALT_INSTR (HALT_INSTR)
    ) u_run_monitor (
        .clk         (clk),
        .reset       (reset),
        .clear       (mon_clear),
        .run         (state == RUN),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .halt_hit    (halt_hit),
        .limit_hit   (limit_hit),
        .cycle_count (cycle_count),
        .halt_pc     (halt_pc),
        .timeout     (timeout)
    );

endmodule

// File: tb/tb_mips_boot_sequencer.sv
// Directed bench for the MIPS boot sequencer with a write scoreboard.
module tb_mips_boot_sequencer;

    localparam int          ADDR_W = 12;
    localparam int          CNT_W  = 32;
    localparam int          MAXC   = 16;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   load_count;
    logic              s_valid;
    logic [31:0]       s_data;
    logic              s_ready;
    logic              cpu_reset;
    logic              init_mode;
    logic              write_enable;
    logic [ADDR_W-1:0] init_address;
    logic [31:0]       init_instruction;
    logic [31:0]       pc_in;
    logic [31:0]       instr_in;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;
    logic [31:0]       halt_pc;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               exp_w;
    int                tests  = 0;
    int                failed = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    mips_boot_sequencer #(
        .ADDR_W     (ADDR_W),
        .RST_CYCLES (2),
        .MAX_CYCLES (MAXC),
        .CNT_W      (CNT_W),
        .HALT_INSTR (HALT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .load_count       (load_count),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .cpu_reset        (cpu_reset),
        .init_mode        (init_mode),
        .write_enable     (write_enable),
        .init_address     (init_address),
        .init_instruction (init_instruction),
        .pc_in            (pc_in),
        .instr_in         (instr_in),
        .busy             (busy),
        .done             (done),
        .timeout          (timeout),
        .cycle_count      (cycle_count),
        .halt_pc          (halt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge, after the scoreboard has sampled
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int a, input logic [31:0] d);
        wr_t w;
        w.addr = ADDR_W'(a);
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Scoreboard: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    failed++;
                    $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write",
                           init_address, init_instruction);
                end
            end else begin
                exp_w = exp_q.pop_front();
                chk("wr_addr", 64'(init_address), 64'(exp_w.addr));
                chk("wr_data", 64'(init_instruction), 64'(exp_w.data));
                last_addr = init_address;
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; load_count = '0;
        s_valid = 1'b0; s_data = '0; pc_in = '0; instr_in = '0;
        tick(); tick();
        chk("rst_cpu_reset", 64'(cpu_reset), 1);
        chk("rst_init_mode", 64'(init_mode), 0);
        chk("rst_we", 64'(write_enable), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_timeout", 64'(timeout), 0);
        chk("rst_count", 64'(cycle_count), 0);
        chk("rst_halt_pc", 64'(halt_pc), 0);
        chk("rst_s_ready", 64'(s_ready), 0);
        chk("rst_addr", 64'(init_address), 0);
        reset = 1'b0;
        tick();

        // Four back-to-back words
        start = 1'b1; load_count = 13'd4; tick(); start = 1'b0;
        chk("l4_ready", 64'(s_ready), 1);
        chk("l4_init_mode", 64'(init_mode), 1);
        chk("l4_cpu_reset", 64'(cpu_reset), 1);
        chk("l4_busy", 64'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'hA000_0000 + i; push(i, s_data);
            tick();
        end
        s_valid = 1'b0; s_data = 32'h0000_0BAD;
        chk("l4_ready_drop", 64'(s_ready), 0);
        chk("l4_last_pulse_init_mode", 64'(init_mode), 1);
        chk("l4_rst1", 64'(cpu_reset), 1);
        tick();
        chk("l4_rst2", 64'(cpu_reset), 1);
        chk("l4_rst2_busy", 64'(busy), 1);
        tick();
        chk("l4_run_cpu_reset", 64'(cpu_reset), 0);
        chk("l4_run_init_mode", 64'(init_mode), 0);
        chk("l4_run_count0", 64'(cycle_count), 0);

        // Halt on run cycle 10
        repeat (10) tick();
        chk("h_count_pre", 64'(cycle_count), 10);
        instr_in = HALT; pc_in = 32'h28; tick();
        instr_in = '0; pc_in = 32'h99;
        chk("h_done", 64'(done), 1);
        chk("h_timeout", 64'(timeout), 0);
        chk("h_count", 64'(cycle_count), 10);
        chk("h_pc", 64'(halt_pc), 64'h28);
        chk("h_cpu_reset", 64'(cpu_reset), 1);
        chk("h_busy", 64'(busy), 0);
        tick();
        chk("h_done_hold", 64'(done), 1);
        chk("h_count_hold", 64'(cycle_count), 10);
        chk("h_pc_hold", 64'(halt_pc), 64'h28);

        // Three words with a gapped valid pattern
        start = 1'b1; load_count = 13'd3; tick(); start = 1'b0;
        chk("g_done_clr", 64'(done), 0);
        chk("g_pc_clr", 64'(halt_pc), 0);
        chk("g_count_clr", 64'(cycle_count), 0);
        chk("g_ready", 64'(s_ready), 1);
        for (int i = 0; i < 5; i++) begin
            s_valid = (i % 2 == 0);
            if (s_valid) begin
                s_data = 32'hB000_0000 + i / 2;
                push(i / 2, s_data);
            end else begin
                s_data = 32'hDEAD_0000 + i;
            end
            tick();
        end
        s_valid = 1'b0;
        chk("g_ready_drop", 64'(s_ready), 0);
        tick();
        chk("g_rst2", 64'(cpu_reset), 1);
        tick();
        chk("g_run", 64'(cpu_reset), 0);

        // Timeout at the 16-cycle limit
        repeat (15) tick();
        chk("t_count_pre", 64'(cycle_count), 15);
        chk("t_done_pre", 64'(done), 0);
        tick();
        chk("t_done", 64'(done), 1);
        chk("t_timeout", 64'(timeout), 1);
        chk("t_count", 64'(cycle_count), MAXC);
        chk("t_cpu_reset", 64'(cpu_reset), 1);

        // Empty load, then halt on the final limit cycle
        start = 1'b1; load_count = '0; tick(); start = 1'b0;
        chk("z_ready", 64'(s_ready), 0);
        chk("z_busy", 64'(busy), 1);
        chk("z_rst1", 64'(cpu_reset), 1);
        chk("z_init_mode", 64'(init_mode), 1);
        chk("z_timeout_clr", 64'(timeout), 0);
        chk("z_done_clr", 64'(done), 0);
        tick();
        chk("z_rst2", 64'(cpu_reset), 1);
        tick();
        chk("z_run", 64'(cpu_reset), 0);
        repeat (15) tick();
        instr_in = HALT; pc_in = 32'h3C; tick();
        instr_in = '0;
        chk("hl_done", 64'(done), 1);
        chk("hl_timeout", 64'(timeout), 0);
        chk("hl_count", 64'(cycle_count), 15);
        chk("hl_pc", 64'(halt_pc), 64'h3C);

        // Abort during load after two of five words
        start = 1'b1; load_count = 13'd5; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 32'hC000_0000 + i; push(i, s_data);
            tick();
        end
        s_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        chk("a_busy", 64'(busy), 0);
        chk("a_init_mode", 64'(init_mode), 0);
        chk("a_ready", 64'(s_ready), 0);
        chk("a_done", 64'(done), 0);
        chk("a_cpu_reset", 64'(cpu_reset), 1);
        chk("a_pc_clr", 64'(halt_pc), 0);
        chk("a_we", 64'(write_enable), 0);
        start = 1'b1; load_count = 13'd1; tick(); start = 1'b0;
        s_valid = 1'b1; s_data = 32'hC1C1_0001; push(0, s_data); tick();
        s_valid = 1'b0;
        chk("a1_ready_drop", 64'(s_ready), 0);
        tick(); tick();
        chk("a1_run", 64'(cpu_reset), 0);
        repeat (3) tick();
        chk("a1_count", 64'(cycle_count), 3);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ar_count_clr", 64'(cycle_count), 0);
        chk("ar_busy", 64'(busy), 0);
        chk("ar_cpu_reset", 64'(cpu_reset), 1);

        // Oversized load count is clamped to the memory size
        start = 1'b1; load_count = 13'd5000; tick(); start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            s_valid = 1'b1; s_data = 32'h5000_0000 ^ i; push(i, s_data);
            tick();
        end
        s_valid = 1'b0;
        chk("c_ready_drop", 64'(s_ready), 0);
        chk("c_last_addr", 64'(last_addr), 4095);
        chk("c_last_we", 64'(write_enable), 1);
        chk("c_last_init_mode", 64'(init_mode), 1);
        tick(); tick();
        chk("c_run", 64'(cpu_reset), 0);
        chk("q_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mips_boot_sequencer.md
Name: mips_boot_sequencer

Overview:
Controller that owns the MIPS core's load/run sequence: it streams a program from a valid/ready word source into instruction memory through the core's init port, then holds the core in reset, releases it, and supervises execution. It watches the core's fetched instruction for a halt word, counts run cycles, and reports done or timeout. It sits between the testbench or host loader and the MIPS top level, and drives the core's reset, init_mode, write_enable, init_address and init_instruction.

Parameters:
ADDR_W, 12, instruction-memory word-address width; matches the core's init_address.
RST_CYCLES, 2, cycles the core's reset is held after loading and before running; must be at least 1.
MAX_CYCLES, 100000, run-cycle limit before timeout.
CNT_W, 32, width of cycle_count.
HALT_INSTR, 32'hFFFF_FFFF, instruction word that ends a run.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset for this block.
start  in  1  begins a load+run; sampled only in IDLE or DONE.
abort  in  1  returns the block to IDLE on the next edge, from any state.
load_count  in  ADDR_W+1  number of words to load; values above 2^ADDR_W are clamped to 2^ADDR_W.
s_valid  in  1  source word valid.
s_data  in  32  source instruction word.
s_ready  out  1  sequencer accepts a word; combinational, equal to (state==LOAD).
cpu_reset  out  1  drives the core's reset.
init_mode  out  1  drives the core's init_mode.
write_enable  out  1  drives the core's write_enable.
init_address  out  ADDR_W  word index into instruction memory.
init_instruction  out  32  word being written.
pc_in  in  32  core pc_out; monitored only.
instr_in  in  32  core instruction_out.
busy  out  1  high in LOAD, RESET_CPU and RUN.
done  out  1  sticky high in DONE.
timeout  out  1  sticky high when DONE was reached by the cycle limit.
cycle_count  out  CNT_W  number of RUN cycles.
halt_pc  out  32  pc_in captured at halt.

Behaviour:
- Reset values: state=IDLE; cpu_reset=1; all other outputs 0; internal word index=0.
- All outputs are registered except s_ready.
- IDLE:
  - start: latch the clamped load_count into n_total, clear done, timeout, cycle_count and halt_pc.
  - If n_total==0, go to RESET_CPU; otherwise go to LOAD.
- LOAD:
  - cpu_reset=1, init_mode=1.
  - Accept a word when s_valid && s_ready.
  - On each accept, the next cycle has write_enable=1 for exactly one cycle, init_address=idx and init_instruction=s_data; then idx increments.
  - With no accept, write_enable=0 on the next cycle.
  - The accept of word n_total-1 moves the state to RESET_CPU. Its write pulse lands in the first RESET_CPU cycle, while init_mode is still 1.
  - idx never exceeds 2^ADDR_W-1; there is no wrap.
- RESET_CPU:
  - cpu_reset=1, init_mode=1 for RST_CYCLES cycles, then go to RUN.
  - init_mode drops together with cpu_reset on entry to RUN.
- RUN:
  - cpu_reset=0, init_mode=0, write_enable=0.
  - cycle_count increments by 1 per cycle and saturates at its maximum value.
  - If instr_in==HALT_INSTR: go to DONE, done=1, halt_pc=pc_in; that cycle is not counted.
  - Otherwise, if cycle_count==MAX_CYCLES-1 at an edge: go to DONE, done=1, timeout=1. Final cycle_count=MAX_CYCLES.
  - If halt and the cycle limit coincide, halt wins and timeout=0.
- DONE:
  - cpu_reset=1; done, timeout, cycle_count and halt_pc hold.
  - start behaves exactly as in IDLE, including clearing the status.
- abort:
  - Highest priority. Next state IDLE, cpu_reset=1, init_mode=0, write_enable=0.
  - Status outputs are cleared; a half-loaded program is left in memory as is.
- start is ignored while busy. s_data is ignored unless s_valid && s_ready.
- busy=1 exactly when the state is LOAD, RESET_CPU or RUN.

Decomposition:
- Shared package: state enum (IDLE, LOAD, RESET_CPU, RUN, DONE) and the default HALT_INSTR constant.
- One sub-module is natural: mips_run_monitor, which holds the RUN cycle counter, the halt/limit compare and the halt_pc capture. The FSM and load datapath stay in the top.

Test Plan:
- start, load_count=4, s_valid held high with words A0..A3 → write_enable pulses on 4 consecutive cycles at addresses 0..3 with the matching data. Then cpu_reset stays high for 2 cycles, then RUN.
- Load 3 words with s_valid toggling 1,0,1,0,1 → exactly 3 write pulses at addresses 0,1,2, none on idle cycles, and s_ready drops after the third accept.
- After RUN entry, drive instr_in=HALT_INSTR on run cycle 10 with pc_in=0x28 → done=1, timeout=0, cycle_count=10, halt_pc=0x28, cpu_reset=1.
- Set MAX_CYCLES=16 and never halt → DONE after 16 RUN cycles with timeout=1 and cycle_count=16. Halt presented on that same final cycle → timeout=0.
- abort during LOAD after 2 of 5 words → IDLE next cycle, init_mode=0, s_ready=0, done=0. A new start with load_count=1 writes at address 0.
- load_count=0 → no write pulses, straight to RESET_CPU and then RUN. load_count=5000 → clamped to 4096 and the last write is at address 4095.
